param_differentiator: RTL and testbench
=======================================

Name: param_differentiator

Overview:
Parametrised derivative stage for the PID datapath. Takes the error sample `e` and computes a span difference, `e[n] - e[n-SPAN]`. Multiplies that difference by the gain `k_d` with a serial shift-add engine (no hardware multiplier), then saturates the result to the output width. Feeds the PID summing stage alongside the proportional and integral contributions, using a valid/busy handshake.

Parameters:
- WIDTH, 6: width of signed error input `e`.
- GAIN_W, 6: width of unsigned gain `k_d`; also the number of multiply iterations.
- OUT_W, 12: width of signed output `d_contrib`; must be >= WIDTH+1.
- SPAN, 1: history distance in samples for the difference (1..8).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- ena, input, 1: global enable; low freezes all state.
- sample_valid, input, 1: new error sample present on `e`.
- e, input, WIDTH: signed two's-complement error sample.
- k_d, input, GAIN_W: unsigned derivative gain; latched when a sample is accepted.
- d_contrib, output, OUT_W: signed, saturated derivative contribution.
- d_valid, output, 1: one-cycle pulse when `d_contrib` updates.
- busy, output, 1: multiply in progress; samples are not accepted.
- sat, output, 1: high while the current `d_contrib` is saturated.
- overrun, output, 1: one-cycle pulse when a sample is dropped because the block is busy.

Behaviour:
- Reset (asynchronous, immediate): clears `d_contrib`, `d_valid`, `busy`, `sat`, `overrun`, history registers, warm-up counter and multiplier registers; FSM goes to IDLE. Reset mid-multiply aborts with no `d_valid`.
- `ena` = 0: nothing changes. FSM, history and outputs hold; `d_valid` and `overrun` are forced 0 and do not fire late.
- Accept rule: a sample is accepted on an edge where `ena` && `sample_valid` && FSM==IDLE.
- On accept:
  - `diff` = `e` - `hist[SPAN-1]`, computed at WIDTH+1 bits signed, so it never wraps.
  - `hist` shifts in `e`; `k_d` is latched.
  - Warm-up: `diff` is forced to 0 until SPAN samples have been accepted since reset (saturating counter).
- `ena` && `sample_valid` && FSM!=IDLE: sample dropped; `overrun` pulses 1 cycle; history is untouched.
- FSM states:
  - IDLE: waits for accept, then goes to MUL with `busy`=1 from the next cycle.
  - MUL: exactly GAIN_W enabled cycles. Iteration i adds (`diff` << i) to a signed WIDTH+1+GAIN_W-bit accumulator when latched `k_d[i]`=1; LSB first. `k_d`=0 gives 0.
  - DONE: 1 cycle. Registers the saturated accumulator into `d_contrib`, updates `sat`, pulses `d_valid`, then returns to IDLE with `busy`=0.
- Latency: accept at edge T; `d_contrib` and `d_valid` are visible after edge T+GAIN_W+1, plus any `ena`-low cycles in between. Throughput is one sample per GAIN_W+2 cycles.
- Saturation: the result is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and `sat`=1 if clamped; otherwise the exact product.
- `d_contrib` holds its value between updates.

Optional Feature:
- Macro: `DIFF_FILTER_EN`.
- Defined: adds a first-order smoothing step. The filtered difference is (`diff` + `prev_diff`) >>> 1, an arithmetic shift that floors toward -inf; it replaces `diff` as the multiplicand.
  - `prev_diff` is updated on each accept.
  - `prev_diff` is reset to 0 and forced to 0 during warm-up.
  - Latency is unchanged.
- Undefined: the raw `diff` is used and no `prev_diff` register exists.

Test Plan:
- Defaults, reset then `k_d`=3, samples `e`=5 then `e`=12 (spaced ≥8 cycles) -> first `d_contrib`=0 (warm-up); second `d_contrib`=21, `d_valid` 7 cycles after accept, `sat`=0.
- `e`=20 then `e`=-20, `k_d`=63 -> `diff`=-40, product -2520, `d_contrib`=-2048, `sat`=1; follow with `e`=-19, `k_d`=1 -> `d_contrib`=1, `sat`=0.
- `sample_valid` asserted 2 cycles after an accept -> `overrun` pulses once, no extra `d_valid`, next accepted sample still differences against the last accepted `e`.
- `ena` low for 5 cycles mid-MUL -> same `d_contrib` value, `d_valid` delayed by exactly 5 cycles, no pulses during the freeze.
- `rst_n` pulled low mid-MUL (no clock edge) -> outputs 0 immediately, `busy`=0, no `d_valid`; warm-up restarts (next first sample gives 0).
- SPAN=3, `k_d`=1, ramp `e`=0,2,4,6,8 -> `d_contrib`=0,0,0,6,6.

Source files
------------

// File: rtl/param_differentiator.sv
// Derivative stage: span difference e[n]-e[n-SPAN], serial shift-add gain multiply, saturated output.
// Optional macro DIFF_FILTER_EN averages the difference with the previous one before the multiply.
module param_differentiator #(
  parameter int WIDTH  = 6,
  parameter int GAIN_W = 6,
  parameter int OUT_W  = 12,
  parameter int SPAN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  e,
  input  logic [GAIN_W-1:0] k_d,
  output logic [OUT_W-1:0]  d_contrib,
  output logic              d_valid,
  output logic              busy,
  output logic              sat,
  output logic              overrun
);

  localparam int DW    = WIDTH + 1;
  localparam int ACC_W = WIDTH + 1 + GAIN_W;
  localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam int CNT_W = $clog2(SPAN + 1);
  localparam int IT_W  = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state_r;
  logic [WIDTH-1:0]         hist_r [SPAN];
  logic [CNT_W-1:0]         warm_r;
  logic [GAIN_W-1:0]        kd_r;
  logic [IT_W-1:0]          iter_r;
  logic signed [ACC_W-1:0]  mcand_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic [OUT_W-1:0]         d_contrib_r;
  logic                     d_valid_r;
  logic                     busy_r;
  logic                     sat_r;
  logic                     overrun_r;

  logic signed [DW-1:0]     raw_diff_s;
  logic signed [DW-1:0]     mult_s;
  logic [OUT_W:0]           sat_res_s;

  // Clamp the accumulator to the output range; MSB of the result is the clamp flag.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] a);
    logic signed [CMP_W-1:0] x;
    logic signed [CMP_W-1:0] hi;
    logic signed [CMP_W-1:0] lo;
    x  = CMP_W'(a);
    hi = '0;
    hi[OUT_W-1:0] = {1'b0, {(OUT_W-1){1'b1}}};
    lo = '1;
    lo[OUT_W-1:0] = {1'b1, {(OUT_W-1){1'b0}}};
    if (x > hi) begin
      saturate = {1'b1, hi[OUT_W-1:0]};
    end else if (x < lo) begin
      saturate = {1'b1, lo[OUT_W-1:0]};
    end else begin
      saturate = {1'b0, x[OUT_W-1:0]};
    end
  endfunction

  // Span difference at WIDTH+1 bits so it cannot wrap; zero until the history is full.
  always_comb begin
    if (warm_r == CNT_W'(SPAN)) begin
      raw_diff_s = $signed({e[WIDTH-1], e}) -
                   $signed({hist_r[SPAN-1][WIDTH-1], hist_r[SPAN-1]});
    end else begin
      raw_diff_s = '0;
    end
    sat_res_s = saturate(acc_r);
  end

`ifdef DIFF_FILTER_EN
  logic signed [DW-1:0] prev_diff_r;
  logic signed [DW:0]   sum_s;

  // Smoothed multiplicand: floor((diff + prev_diff) / 2).
  always_comb begin
    sum_s  = $signed({raw_diff_s[DW-1], raw_diff_s}) + $signed({prev_diff_r[DW-1], prev_diff_r});
    mult_s = DW'(sum_s >>> 1);
  end

  // Previous raw difference, zero during warm-up because raw_diff_s is zero then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_diff_r <= '0;
    end else if (ena && sample_valid && state_r == ST_IDLE) begin
      prev_diff_r <= raw_diff_s;
    end else begin
      prev_diff_r <= prev_diff_r;
    end
  end
`else
  // Raw difference feeds the multiplier directly.
  always_comb begin
    mult_s = raw_diff_s;
  end
`endif

  // Control FSM, history, serial multiplier and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      for (int k = 0; k < SPAN; k++) begin
        hist_r[k] <= '0;
      end
      warm_r      <= '0;
      kd_r        <= '0;
      iter_r      <= '0;
      mcand_r     <= '0;
      acc_r       <= '0;
      d_contrib_r <= '0;
      d_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
      sat_r       <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      d_valid_r <= 1'b0;
      overrun_r <= 1'b0;
      if (ena) begin
        case (state_r)
          ST_IDLE: begin
            if (sample_valid) begin
              for (int k = SPAN - 1; k > 0; k--) begin
                hist_r[k] <= hist_r[k-1];
              end
              hist_r[0] <= e;
              if (warm_r != CNT_W'(SPAN)) begin
                warm_r <= warm_r + CNT_W'(1);
              end
              kd_r    <= k_d;
              mcand_r <= ACC_W'(mult_s);
              acc_r   <= '0;
              iter_r  <= '0;
              busy_r  <= 1'b1;
              state_r <= ST_MUL;
            end
          end
          ST_MUL: begin
            // LSB-first: iteration i adds diff << i when gain bit i is set.
            if (kd_r[0]) begin
              acc_r <= acc_r + mcand_r;
            end
            mcand_r <= mcand_r <<< 1;
            kd_r    <= kd_r >> 1;
            iter_r  <= iter_r + IT_W'(1);
            if (iter_r == IT_W'(GAIN_W - 1)) begin
              state_r <= ST_DONE;
            end
            overrun_r <= sample_valid;
          end
          ST_DONE: begin
            sat_r       <= sat_res_s[OUT_W];
            d_contrib_r <= sat_res_s[OUT_W-1:0];
            d_valid_r   <= 1'b1;
            busy_r      <= 1'b0;
            overrun_r   <= sample_valid;
            state_r     <= ST_IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign d_contrib = d_contrib_r;
  assign d_valid   = d_valid_r;
  assign busy      = busy_r;
  assign sat       = sat_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_param_differentiator.sv
// Bench for param_differentiator: SPAN=1 and SPAN=3 instances share stimulus; a sample-level
// model predicts every output each cycle, plus directed checks of the documented scenarios.
module tb_param_differentiator;

  localparam int WIDTH  = 6;
  localparam int GAIN_W = 6;
  localparam int OUT_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              sample_valid;
  logic [WIDTH-1:0]  e;
  logic [GAIN_W-1:0] k_d;
  logic [OUT_W-1:0]  d1, d3;
  logic              dv1, dv3, busy1, busy3, sat1, sat3, ov1, ov3;

  always #5 clk = ~clk;

  param_differentiator #(.WIDTH(WIDTH), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .SPAN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_valid(sample_valid), .e(e), .k_d(k_d),
    .d_contrib(d1), .d_valid(dv1), .busy(busy1), .sat(sat1), .overrun(ov1));

  param_differentiator #(.WIDTH(WIDTH), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .SPAN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_valid(sample_valid), .e(e), .k_d(k_d),
    .d_contrib(d3), .d_valid(dv3), .busy(busy3), .sat(sat3), .overrun(ov3));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int hist_q[$];
  int n_acc = 0;
  int remain = 0;
  int prev_m [2] = '{0, 0};
  int pend_v [2] = '{0, 0};
  int exp_d  [2] = '{0, 0};
  int exp_sat[2] = '{0, 0};
  int exp_dv = 0, exp_ov = 0, exp_busy = 0;

  logic              cap_live;
  logic              cap_ena, cap_sv;
  logic [WIDTH-1:0]  cap_e;
  logic [GAIN_W-1:0] cap_k;

  function automatic int span_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int floor_half(input int s);
    return (s >= 0) ? s / 2 : -((-s + 1) / 2);
  endfunction

  // Capture the inputs each rising edge sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_live <= 1'b0;
    end else begin
      cap_live <= 1'b1;
      cap_ena  <= ena;
      cap_sv   <= sample_valid;
      cap_e    <= e;
      cap_k    <= k_d;
    end
  end

  task automatic model_step();
    int ev, raw, m, lim;
    exp_dv = 0;
    exp_ov = 0;
    if (cap_ena) begin
      if (remain == 0) begin
        if (cap_sv) begin
          ev = $signed(cap_e);
          for (int i = 0; i < 2; i++) begin
            raw = (n_acc >= span_of(i)) ? ev - hist_q[n_acc - span_of(i)] : 0;
`ifdef DIFF_FILTER_EN
            m = floor_half(raw + prev_m[i]);
            prev_m[i] = raw;
`else
            m = raw;
`endif
            pend_v[i] = m * int'(cap_k);
          end
          hist_q.push_back(ev);
          n_acc++;
          remain = GAIN_W + 1;
        end
      end else begin
        if (cap_sv) exp_ov = 1;
        remain--;
        if (remain == 0) begin
          exp_dv = 1;
          lim = 1 << (OUT_W - 1);
          for (int i = 0; i < 2; i++) begin
            if (pend_v[i] > lim - 1) begin
              exp_d[i] = lim - 1; exp_sat[i] = 1;
            end else if (pend_v[i] < -lim) begin
              exp_d[i] = -lim; exp_sat[i] = 1;
            end else begin
              exp_d[i] = pend_v[i]; exp_sat[i] = 0;
            end
          end
        end
      end
    end
    exp_busy = (remain != 0) ? 1 : 0;
  endtask

  // Advance the model one edge and compare every output of both instances.
  always @(negedge clk) begin
    if (!rst_n) begin
      hist_q.delete();
      n_acc = 0; remain = 0; exp_dv = 0; exp_ov = 0; exp_busy = 0;
      for (int i = 0; i < 2; i++) begin
        prev_m[i] = 0; pend_v[i] = 0; exp_d[i] = 0; exp_sat[i] = 0;
      end
    end else if (cap_live) begin
      model_step();
      check("m_dv1",   int'(dv1),   exp_dv);
      check("m_ov1",   int'(ov1),   exp_ov);
      check("m_busy1", int'(busy1), exp_busy);
      check("m_d1",    int'($signed(d1)), exp_d[0]);
      check("m_sat1",  int'(sat1),  exp_sat[0]);
      check("m_dv3",   int'(dv3),   exp_dv);
      check("m_d3",    int'($signed(d3)), exp_d[1]);
      check("m_sat3",  int'(sat3),  exp_sat[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input int ev, input int kv, output int g1, output int g3, output int lat);
    @(negedge clk);
    e = WIDTH'(ev); k_d = GAIN_W'(kv); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    lat = 0;
    while (dv1 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    g1 = $signed(d1);
    g3 = $signed(d3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int g1, g3, lat, nov, ndv;
  int ramp_exp[5] = '{0, 0, 0, 6, 6};

  initial begin
    rst_n = 1'b0; ena = 1'b1; sample_valid = 1'b0; e = '0; k_d = '0;
    repeat (3) @(negedge clk);
    check("rst_d",    int'(d1),    0);
    check("rst_busy", int'(busy1), 0);
    check("rst_dv",   int'(dv1),   0);
    check("rst_sat",  int'(sat1),  0);
    check("rst_ov",   int'(ov1),   0);
    rst_n = 1'b1;

    send(5, 3, g1, g3, lat);
    check("warm_lat", lat, 7);
    check("warm_d", g1, 0);
    send(12, 3, g1, g3, lat);
    check("k3_lat", lat, 7);
`ifndef DIFF_FILTER_EN
    check("k3_d", g1, 21);
    check("k3_sat", int'(sat1), 0);
`endif
    send(20, 63, g1, g3, lat);
    send(-20, 63, g1, g3, lat);
`ifndef DIFF_FILTER_EN
    check("neg_sat_d", g1, -2048);
    check("neg_sat", int'(sat1), 1);
`endif
    send(-19, 1, g1, g3, lat);
`ifndef DIFF_FILTER_EN
    check("small_d", g1, 1);
    check("small_sat", int'(sat1), 0);
`endif

    // Dropped sample two cycles after an accept.
    @(negedge clk);
    e = WIDTH'(-10); k_d = GAIN_W'(1); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    e = WIDTH'(30); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    nov = 0; ndv = 0;
    for (int n = 0; n < 12; n++) begin
      nov += int'(ov1);
      ndv += int'(dv1);
      if (n == 4) begin
`ifndef DIFF_FILTER_EN
        check("ovr_hold_d", int'($signed(d1)), 1);
`endif
      end
      @(negedge clk);
    end
    check("ovr_pulses", nov, 1);
    check("ovr_dvalids", ndv, 1);
`ifndef DIFF_FILTER_EN
    check("ovr_res", int'($signed(d1)), 9);
`endif
    send(0, 1, g1, g3, lat);
`ifndef DIFF_FILTER_EN
    check("ovr_hist", g1, 10);
`endif

    // Freeze five cycles mid-multiply.
    @(negedge clk);
    e = WIDTH'(5); k_d = GAIN_W'(2); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    lat = 0; ndv = 0;
    while (dv1 !== 1'b1 && lat < 40) begin
      if (lat == 3) ena = 1'b0;
      if (lat == 8) ena = 1'b1;
      @(negedge clk);
      lat++;
      if (!ena) ndv += int'(dv1) + int'(ov1);
    end
    ena = 1'b1;
    check("frz_lat", lat, 12);
    check("frz_pulses", ndv, 0);
`ifndef DIFF_FILTER_EN
    check("frz_d", int'($signed(d1)), 10);
`endif

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    e = WIDTH'(7); k_d = GAIN_W'(5); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_d",    int'(d1),    0);
    check("arst_busy", int'(busy1), 0);
    check("arst_sat",  int'(sat1),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndv = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      ndv += int'(dv1);
    end
    check("arst_no_dv", ndv, 0);
    send(9, 5, g1, g3, lat);
    check("arst_warm", g1, 0);

    // SPAN=3 ramp.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(2 * i, 1, g1, g3, lat);
`ifndef DIFF_FILTER_EN
      check($sformatf("ramp3_%0d", i), g3, ramp_exp[i]);
`endif
    end

    // Randomized traffic, checked by the model every cycle.
    ndv = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ndv += int'(dv1);
      ena          = ($urandom_range(0, 9) != 0);
      sample_valid = ($urandom_range(0, 2) == 0);
      e            = WIDTH'($urandom);
      k_d          = GAIN_W'($urandom);
    end
    sample_valid = 1'b0;
    ena = 1'b1;
    repeat (20) @(negedge clk);
    check("rand_activity", int'(ndv > 50), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
